// File: rtl/riscv_ex_pkg.sv
// Shared EX-side types: default payload width, arbiter state encoding, tag width helper.
package riscv_ex_pkg;
  localparam int EX_DW = 32;

  typedef enum logic {ARB = 1'b0, LOCK = 1'b1} arb_state_e;

  function automatic int tag_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/riscv_ex_arb_tagq.sv
// Synchronous FIFO of issuer tags, one entry per op in flight in the EX pipe.
module riscv_ex_arb_tagq #(
  parameter int IDW    = 1,
  parameter int QDEPTH = 4
) (
  input  logic           clk,
  input  logic           rstn,
  input  logic           push,
  input  logic           pop,
  input  logic [IDW-1:0] din,
  output logic [IDW-1:0] dout,
  output logic           full,
  output logic           empty
);
  localparam int PW = $clog2(QDEPTH);

  logic [QDEPTH-1:0][IDW-1:0] mem_q;
  logic [PW-1:0]              wr_q, rd_q;
  logic [PW:0]                cnt_q;
  logic                       do_push, do_pop;

  assign full    = (cnt_q == (PW+1)'(QDEPTH));
  assign empty   = (cnt_q == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign dout    = mem_q[rd_q];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      mem_q <= '0;
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_q] <= din;
        wr_q        <= wr_q + PW'(1);
      end
      if (do_pop) rd_q <= rd_q + PW'(1);
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + (PW+1)'(1);
        2'b01:   cnt_q <= cnt_q - (PW+1)'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end
endmodule

// File: rtl/riscv_ex_arb.sv
// Round-robin arbiter sharing one EX pipe between NREQ issuers; results routed back in issue order.
// Optional per-requester grant counters when RISCV_EX_ARB_STATS_EN is defined.
module riscv_ex_arb
  import riscv_ex_pkg::*;
#(
  parameter int NREQ   = 2,
  parameter int DW     = EX_DW,
  parameter int QDEPTH = 4
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic [NREQ-1:0]    req_rdy,
  output logic [NREQ-1:0]    req_ack,
  input  logic [NREQ*DW-1:0] req_data,
  output logic [NREQ-1:0]    rsp_rdy,
  input  logic [NREQ-1:0]    rsp_ack,
  output logic [DW-1:0]      rsp_data,
  output logic               id_ex_rdy,
  input  logic               id_ex_ack,
  output logic [DW-1:0]      id_ex_data,
  input  logic               mem_wb_rdy,
  output logic               mem_wb_ack,
  input  logic [DW-1:0]      mem_wb_data,
  output logic               err_orphan
`ifdef RISCV_EX_ARB_STATS_EN
  ,
  output logic [NREQ*16-1:0] grant_cnt
`endif
);
  localparam int IDW = tag_w(NREQ);

  arb_state_e     state_q, state_d;
  logic [IDW-1:0] lock_id_q, lock_id_d, rr_ptr_q, rr_ptr_d;
  logic [IDW-1:0] rr_grant, grant, head;
  logic           err_q, err_d;
  logic           any_rdy, issue, pop, q_full, q_empty, rr_found;

  // First requesting index at or above rr_ptr, wrapping modulo NREQ.
  always_comb begin
    rr_grant = rr_ptr_q;
    rr_found = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      if (!rr_found && req_rdy[IDW'((int'(rr_ptr_q) + k) % NREQ)]) begin
        rr_grant = IDW'((int'(rr_ptr_q) + k) % NREQ);
        rr_found = 1'b1;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    lock_id_d = lock_id_q;
    rr_ptr_d  = rr_ptr_q;
    grant     = (state_q == LOCK) ? lock_id_q : rr_grant;
    any_rdy   = (state_q == LOCK) ? req_rdy[lock_id_q] : |req_rdy;
    id_ex_rdy = any_rdy & ~q_full;
    issue     = id_ex_rdy & id_ex_ack;
    req_ack   = '0;
    req_ack[grant] = issue;
    case (state_q)
      ARB:  if (id_ex_rdy && !id_ex_ack) begin
              state_d   = LOCK;
              lock_id_d = grant;
            end
      // A locked requester that drops rdy breaks protocol; recover by re-arbitrating.
      LOCK: if (issue || !req_rdy[lock_id_q]) state_d = ARB;
      default: state_d = ARB;
    endcase
    if (issue) rr_ptr_d = (grant == IDW'(NREQ-1)) ? '0 : grant + IDW'(1);
  end

  always_comb begin
    id_ex_data = '0;
    for (int i = 0; i < NREQ; i++)
      if (grant == IDW'(i)) id_ex_data = req_data[i*DW +: DW];
  end

  always_comb begin
    rsp_rdy       = '0;
    rsp_rdy[head] = mem_wb_rdy & ~q_empty;
    rsp_data      = mem_wb_data;
    pop           = mem_wb_rdy & ~q_empty & rsp_ack[head];
    mem_wb_ack    = pop;
    err_d         = err_q | (mem_wb_rdy & q_empty);
  end

  assign err_orphan = err_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= ARB;
      lock_id_q <= '0;
      rr_ptr_q  <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      lock_id_q <= lock_id_d;
      rr_ptr_q  <= rr_ptr_d;
      err_q     <= err_d;
    end
  end

  riscv_ex_arb_tagq #(.IDW(IDW), .QDEPTH(QDEPTH)) u_tagq (
    .clk   (clk),
    .rstn  (rstn),
    .push  (issue),
    .pop   (pop),
    .din   (grant),
    .dout  (head),
    .full  (q_full),
    .empty (q_empty)
  );

`ifdef RISCV_EX_ARB_STATS_EN
  logic [NREQ-1:0][15:0] cnt_q;

  for (genvar i = 0; i < NREQ; i++) begin : g_cnt
    always_ff @(posedge clk or negedge rstn) begin
      if (!rstn)
        cnt_q[i] <= '0;
      else if (issue && grant == IDW'(i) && cnt_q[i] != 16'hFFFF)
        cnt_q[i] <= cnt_q[i] + 16'd1;
    end
  end

  assign grant_cnt = cnt_q;
`endif
endmodule

// File: tb/tb_riscv_ex_arb.sv
// Bench for riscv_ex_arb: directed scenarios plus randomized traffic against a queue-based reference model.
module tb_riscv_ex_arb;
  localparam int NREQ = 2, DW = 32, QDEPTH = 4;
  localparam logic [DW-1:0] RMASK = 32'hFFFF0000;

  logic               clk = 1'b0, rstn;
  logic [NREQ-1:0]    req_rdy, req_ack, rsp_rdy, rsp_ack;
  logic [NREQ*DW-1:0] req_data;
  logic [DW-1:0]      rsp_data, id_ex_data, mem_wb_data;
  logic               id_ex_rdy, id_ex_ack, mem_wb_rdy, mem_wb_ack, err_orphan;
`ifdef RISCV_EX_ARB_STATS_EN
  logic [NREQ*16-1:0] grant_cnt;
`endif

  int errors = 0, checks = 0;

  typedef struct { int id; logic [DW-1:0] d; } op_t;
  op_t infl[$];
  int  next_ptr, pend_id;
  bit  pend_v;

  riscv_ex_arb #(.NREQ(NREQ), .DW(DW), .QDEPTH(QDEPTH)) dut (
    .clk(clk), .rstn(rstn), .req_rdy(req_rdy), .req_ack(req_ack), .req_data(req_data),
    .rsp_rdy(rsp_rdy), .rsp_ack(rsp_ack), .rsp_data(rsp_data),
    .id_ex_rdy(id_ex_rdy), .id_ex_ack(id_ex_ack), .id_ex_data(id_ex_data),
    .mem_wb_rdy(mem_wb_rdy), .mem_wb_ack(mem_wb_ack), .mem_wb_data(mem_wb_data),
    .err_orphan(err_orphan)
`ifdef RISCV_EX_ARB_STATS_EN
    , .grant_cnt(grant_cnt)
`endif
  );

  always #5 clk = ~clk;

  // An offered but not yet accepted op must stay offered.
  for (genvar i = 0; i < NREQ; i++) begin : g_hold
    assert property (@(posedge clk) disable iff (!rstn) (req_rdy[i] && !req_ack[i]) |=> req_rdy[i])
      else $error("req_rdy[%0d] dropped before ack", i);
  end

  function automatic int scan(input int p, input logic [NREQ-1:0] r);
    for (int k = 0; k < NREQ; k++) if (r[(p + k) % NREQ]) return (p + k) % NREQ;
    return 0;
  endfunction

  function automatic logic [NREQ-1:0] oh(input int g);
    logic [NREQ-1:0] v;
    v = '0;
    v[g] = 1'b1;
    return v;
  endfunction

  task automatic zero_inputs();
    req_rdy = '0; req_data = '0; rsp_ack = '0; id_ex_ack = 1'b0;
    mem_wb_rdy = 1'b0; mem_wb_data = '0;
  endtask

  task automatic do_reset();
    @(negedge clk); rstn = 1'b0;
    @(negedge clk); zero_inputs();
    @(negedge clk); rstn = 1'b1;
    infl.delete(); next_ptr = 0; pend_v = 1'b0;
  endtask

  task automatic test_reset();
    logic [DW+2*NREQ+2:0] outs;
    zero_inputs();
    rstn = 1'b0;
    repeat (2) @(negedge clk);
    outs = {id_ex_rdy, req_ack, rsp_rdy, mem_wb_ack, err_orphan, id_ex_data};
    checks++;
    if (outs !== '0) begin errors++; $display("FAIL reset_outs: got %h want 0", outs); end
    rstn = 1'b1;
    @(negedge clk); #1;
    outs = {id_ex_rdy, req_ack, rsp_rdy, mem_wb_ack, err_orphan, id_ex_data};
    checks++;
    if (outs !== '0) begin errors++; $display("FAIL post_reset_outs: got %h want 0", outs); end
    infl.delete(); next_ptr = 0; pend_v = 1'b0;
  endtask

  task automatic test_alternate();
    do_reset();
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      req_rdy = 2'b11; req_data = {32'h2000_0000 + k, 32'h1000_0000 + k};
      id_ex_ack = 1'b1; rsp_ack = 2'b11;
      mem_wb_rdy = (k > 0); mem_wb_data = 32'hBEEF_0000 + k;
      #1;
      checks++;
      if (req_ack !== oh(k % 2)) begin errors++; $display("FAIL alt_grant[%0d]: got %b want %b", k, req_ack, oh(k % 2)); end
      checks++;
      if (rsp_rdy !== ((k > 0) ? oh((k - 1) % 2) : 2'b00))
        begin errors++; $display("FAIL alt_rsp[%0d]: got %b want %b", k, rsp_rdy, (k > 0) ? oh((k - 1) % 2) : 2'b00); end
    end
  endtask

  task automatic test_lock();
    do_reset();
    @(negedge clk); req_rdy = 2'b01; req_data = '0; id_ex_ack = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      req_rdy = (k == 0) ? 2'b01 : 2'b11;
      req_data = {32'h1111_1111, 32'hA5A5_A5A5};
      id_ex_ack = (k == 3);
      #1;
      checks++;
      if (id_ex_data !== 32'hA5A5_A5A5) begin errors++; $display("FAIL lock_data[%0d]: got %h want a5a5a5a5", k, id_ex_data); end
      checks++;
      if (req_ack !== ((k == 3) ? 2'b01 : 2'b00)) begin errors++; $display("FAIL lock_ack[%0d]: got %b", k, req_ack); end
    end
    @(negedge clk); req_rdy = 2'b10; id_ex_ack = 1'b1; #1;
    checks++;
    if (req_ack !== 2'b10 || id_ex_data !== 32'h1111_1111)
      begin errors++; $display("FAIL lock_next: got ack %b data %h want 10 11111111", req_ack, id_ex_data); end
  endtask

  task automatic test_full();
    int issued = 0;
    do_reset();
    for (int k = 0; k < 6; k++) begin
      @(negedge clk); req_rdy = 2'b11; id_ex_ack = 1'b1; req_data = {32'hC1, 32'hC0}; #1;
      if (req_ack != 0) issued++;
      checks++;
      if (id_ex_rdy !== (k < 4)) begin errors++; $display("FAIL full_rdy[%0d]: got %b want %b", k, id_ex_rdy, k < 4); end
    end
    checks++;
    if (issued != 4) begin errors++; $display("FAIL full_issued: got %0d want 4", issued); end
    @(negedge clk); mem_wb_rdy = 1'b1; rsp_ack = 2'b11; #1;
    checks++;
    if ({mem_wb_ack, id_ex_rdy} !== 2'b10) begin errors++; $display("FAIL full_pop: got ack,rdy %b want 10", {mem_wb_ack, id_ex_rdy}); end
    @(negedge clk); mem_wb_rdy = 1'b0; #1;
    checks++;
    if ({id_ex_rdy, req_ack} !== 3'b101) begin errors++; $display("FAIL full_fifth: got %b want 101", {id_ex_rdy, req_ack}); end
  endtask

  task automatic test_orphan();
    do_reset();
    @(negedge clk); mem_wb_rdy = 1'b1; rsp_ack = 2'b11; #1;
    checks++;
    if ({mem_wb_ack, rsp_rdy, err_orphan} !== 4'b0) begin errors++; $display("FAIL orphan_ack: got %b want 0000", {mem_wb_ack, rsp_rdy, err_orphan}); end
    @(negedge clk); mem_wb_rdy = 1'b0; #1;
    checks++;
    if (err_orphan !== 1'b1) begin errors++; $display("FAIL orphan_set: got %b want 1", err_orphan); end
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if (err_orphan !== 1'b1) begin errors++; $display("FAIL orphan_sticky: got %b want 1", err_orphan); end
  endtask

  task automatic test_reset_midflight();
    logic [DW+2*NREQ+2:0] outs;
    do_reset();
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); req_rdy = 2'b11; id_ex_ack = 1'b1; req_data = {32'hD1, 32'hD0};
    end
    @(negedge clk); rstn = 1'b0;
    @(negedge clk); zero_inputs(); #1;
    outs = {id_ex_rdy, req_ack, rsp_rdy, mem_wb_ack, err_orphan, id_ex_data};
    checks++;
    if (outs !== '0) begin errors++; $display("FAIL mid_reset_outs: got %h want 0", outs); end
    @(negedge clk); rstn = 1'b1; #1;
    outs = {id_ex_rdy, req_ack, rsp_rdy, mem_wb_ack, err_orphan, id_ex_data};
    checks++;
    if (outs !== '0) begin errors++; $display("FAIL mid_after_outs: got %h want 0", outs); end
    @(negedge clk); mem_wb_rdy = 1'b1; rsp_ack = 2'b11; req_rdy = 2'b11; id_ex_ack = 1'b1; #1;
    checks++;
    if ({mem_wb_ack, req_ack} !== 3'b001) begin errors++; $display("FAIL mid_first: got %b want 001", {mem_wb_ack, req_ack}); end
  endtask

  task automatic test_random(input int ncyc, input bit stall);
    int g; bit iss, pp, exp_rdy; logic [NREQ-1:0] exp_ack;
    do_reset();
    for (int c = 0; c < ncyc; c++) begin
      @(negedge clk);
      for (int i = 0; i < NREQ; i++)
        if (!req_rdy[i] && $urandom_range(0, 99) < 60) begin
          req_rdy[i] = 1'b1; req_data[i*DW +: DW] = $urandom;
        end
      id_ex_ack = stall ? ($urandom_range(0, 99) < 60) : 1'b1;
      rsp_ack   = stall ? NREQ'($urandom) : '1;
      if (!mem_wb_rdy && infl.size() > 0 && (!stall || $urandom_range(0, 99) < 50)) begin
        mem_wb_rdy = 1'b1; mem_wb_data = infl[0].d ^ RMASK;
      end
      #1;
      g       = pend_v ? pend_id : scan(next_ptr, req_rdy);
      exp_rdy = (req_rdy != 0) && (infl.size() < QDEPTH);
      exp_ack = (exp_rdy && id_ex_ack) ? oh(g) : '0;
      checks++;
      if (id_ex_rdy !== exp_rdy) begin errors++; $display("FAIL rnd_rdy@%0d: got %b want %b", c, id_ex_rdy, exp_rdy); end
      checks++;
      if (req_ack !== exp_ack) begin errors++; $display("FAIL rnd_ack@%0d: got %b want %b", c, req_ack, exp_ack); end
      if (exp_rdy) begin
        checks++;
        if (id_ex_data !== req_data[g*DW +: DW]) begin errors++; $display("FAIL rnd_data@%0d: got %h want %h", c, id_ex_data, req_data[g*DW +: DW]); end
      end
      pp = 1'b0;
      if (mem_wb_rdy) begin
        pp = rsp_ack[infl[0].id];
        checks++;
        if (rsp_rdy !== oh(infl[0].id) || mem_wb_ack !== pp || rsp_data !== (infl[0].d ^ RMASK))
          begin errors++; $display("FAIL rnd_rsp@%0d: got rdy %b ack %b data %h want %b %b %h", c, rsp_rdy, mem_wb_ack, rsp_data, oh(infl[0].id), pp, infl[0].d ^ RMASK); end
      end else begin
        checks++;
        if ({rsp_rdy, mem_wb_ack} !== '0) begin errors++; $display("FAIL rnd_idle@%0d: got %b want 0", c, {rsp_rdy, mem_wb_ack}); end
      end
      checks++;
      if (err_orphan !== 1'b0) begin errors++; $display("FAIL rnd_orphan@%0d: got 1 want 0", c); end
      iss = exp_rdy && id_ex_ack;
      @(posedge clk); #1;
      if (pp) begin void'(infl.pop_front()); mem_wb_rdy = 1'b0; end
      if (iss) begin
        infl.push_back('{g, req_data[g*DW +: DW]});
        next_ptr = (g + 1) % NREQ;
        req_rdy[g] = 1'b0;
      end
      pend_v = exp_rdy && !id_ex_ack; pend_id = g;
    end
  endtask

`ifdef RISCV_EX_ARB_STATS_EN
  task automatic test_stats();
    do_reset();
    for (int k = 0; k < 70000; k++) begin
      @(negedge clk);
      req_rdy = 2'b10; id_ex_ack = 1'b1; rsp_ack = 2'b11; mem_wb_rdy = (k > 0);
    end
    @(negedge clk); req_rdy = 2'b00; mem_wb_rdy = 1'b0; #1;
    checks++;
    if (grant_cnt !== {16'hFFFF, 16'h0000}) begin errors++; $display("FAIL stats_cnt: got %h want ffff0000", grant_cnt); end
  endtask
`endif

  initial begin
    test_reset();
    test_alternate();
    test_lock();
    test_full();
    test_orphan();
    test_reset_midflight();
    test_random(1500, 1'b1);
    test_random(600, 1'b0);
`ifdef RISCV_EX_ARB_STATS_EN
    test_stats();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
